acc_cpu_gen2: RTL
=================

# acc_cpu_gen2

Parametrised second-generation accumulator CPU for a TinyTapeout tile. Executes one 8-bit instruction per strobe: 4-bit opcode, 4-bit immediate. Adds over the 4-bit accumulator core:
- configurable data width
- a small scratch register file
- carry and zero flags
- a multi-cycle shift-add multiplier with a busy indication

It sits directly behind the tile's dedicated I/O pins.

## Interface
- DATA_W, 8, accumulator/register width; legal 4..8
- NREG, 4, scratch registers; legal 2 or 4 (index = imm[log2(NREG)-1:0])

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  tile enable; 0 freezes all state
- ui_in  in  8  instruction: [7:4] opcode, [3:0] imm
- uio_in  in  8  [0] strobe; [1] readback mode; [3:2] readback register index; others ignored
- uo_out  out  8  acc, or reg[uio_in[3:2]] when uio_in[1]=1, zero-extended to 8
- uio_out  out  8  [7] busy, [6] C, [5] Z, [4:0]=0
- uio_oe  out  8  constant 8'hE0

## Operation
- Accept condition: rising edge with ena=1, strobe=1, busy=0. Each accepting edge executes one instruction, so a held strobe executes repeatedly.
- A strobe while busy=1 is dropped, not queued.
- Immediate: imm zero-extended to DATA_W. All arithmetic is modulo 2^DATA_W.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 ADD: acc+=imm; C=carry-out.
  - 3 SUB: acc-=imm; C=1 on borrow (acc<imm).
  - 4 AND, 5 OR, 6 XOR with imm; C unchanged.
  - 7 ADC: acc=acc+imm+C; C=carry-out.
  - 8 ST: reg[idx]=acc.
  - 9 LD: acc=reg[idx].
  - A ADDR: acc+=reg[idx]; C=carry-out.
  - B SHL: C=acc[MSB], acc<<1, shift in 0.
  - C SHR: C=acc[0], acc>>1, shift in 0.
  - D LDH: acc[7:4]=imm (bits ≥DATA_W dropped); NOP when DATA_W=4.
  - E MUL: acc=(acc*imm) mod 2^DATA_W. C=1 if any product bit ≥DATA_W is set.
  - F CLR: acc=0, C=0.
- For idx ≥ NREG with NREG=2, only imm[0] is used.
- Z is combinational (acc==0), so it is always current.
- MUL state machine: IDLE → MUL1 → MUL2 → MUL3 → MUL4 → IDLE.
  - On accept, capture multiplicand=acc and multiplier=imm; clear the 2*DATA_W-bit partial product.
  - Each MULn state adds multiplicand<<(n-1) when multiplier bit n-1 is 1.
  - acc and C are written on the MUL4 edge.
  - busy=1 in MUL1..MUL4.
- Readback mode affects uo_out only, never state.

## Timing
- Reset (async, immediate on rst_n=0): acc=0, all regs=0, C=0, FSM=IDLE.
  - Outputs after reset: uo_out=0, uio_out=8'h20 (Z=1), uio_oe=8'hE0.
- Single-cycle ops: result and flags visible on uo_out/uio_out right after the accepting edge (latency 1).
- MUL:
  - Accepting edge N sets busy=1.
  - acc/C update at edge N+4; busy=0 after N+4.
  - The next instruction can be accepted at edge N+5.
  - During busy, uo_out shows the old acc.
- ena=0: no accept, FSM does not advance (MUL stalls mid-sequence), outputs hold. Resumes where it stopped when ena returns to 1.
- Reset mid-MUL: abort immediately, no partial write, busy=0.
- Readback select is combinational, with no latency.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → uo_out=8'h00, uio_out=8'h20, uio_oe=8'hE0. Assert rst_n=0 mid-sequence → same values asynchronously.
- Wrap and carry (DATA_W=8): LDI F, LDH F → 8'hFF; ADD 1 → uo_out=8'h00, C=1, Z=1; ADC 0 → 8'h01, C=0. Repeat with DATA_W=4: LDI F, ADD 1 → 0, C=1.
- MUL:
  - LDI 7, MUL 6 → busy=1 for 4 cycles, then uo_out=8'h2A, C=0.
  - LDI F, LDH F, MUL 2 → 8'hFE, C=1.
  - Strobe ADD 1 during busy → result still 8'h2A.
- Registers: LDI 5, ST r2, CLR, ADDR r2 → uo_out=8'h05. uio_in[1]=1 with idx 2 → uo_out=8'h05 while acc is unchanged.
- Shifts/logic: LDI 9, SHR → 8'h04, C=1; SHL ×2 → 8'h10, C=0; XOR F → 8'h1F; SUB F with acc=8'h1F → 8'h10, C=0.
- Stall/abort:
  - Start MUL 3 on acc=5; drop ena for 3 cycles mid-MUL → busy held. Re-enable → 8'h0F after the remaining cycles.
  - Repeat and pulse rst_n=0 at the second busy cycle → acc=0, busy=0.

Source files
------------

// File: rtl/acc_cpu_gen2.sv
// rtl/acc_cpu_gen2.sv - parametrised accumulator CPU with scratch regs, C/Z flags and shift-add MUL
module acc_cpu_gen2 #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int IDX_W = (NREG > 2) ? 2 : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL1 = 3'd1;
  localparam logic [2:0] S_MUL4 = 3'd4;

  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                c_q, c_d;
  logic [2:0]          state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [3:0]          mplier_q, mplier_d;
  logic [2*DATA_W-1:0] pp_q, pp_d;

  logic [3:0]          opcode, imm, acc_lo;
  logic [DATA_W-1:0]   imm_ext, reg_rd;
  logic [IDX_W-1:0]    idx, rb_idx;
  logic                busy, accept;
  logic [DATA_W:0]     sum_w;
  logic [7:0]          ldh_w;
  logic [1:0]          step;
  logic [2*DATA_W-1:0] pp_next;
  logic                unused_ok;

  assign unused_ok = &{1'b0, uio_in[7:4], uio_in[3]};

  always_comb begin
    opcode  = ui_in[7:4];
    imm     = ui_in[3:0];
    imm_ext = DATA_W'(imm);
    idx     = imm[IDX_W-1:0];
    reg_rd  = regs_q[idx];
    busy    = (state_q != S_IDLE);
    accept  = ena & uio_in[0] & ~busy;
    acc_lo  = 4'(acc_q);
    ldh_w   = {imm, acc_lo};
    // MULn handles multiplier bit n-1; state encoding 1..4 maps onto 0..3 in two bits
    step    = state_q[1:0] - 2'd1;
    pp_next = pp_q + (mplier_q[step] ? ((2*DATA_W)'(mcand_q) << step) : '0);
    sum_w   = '0;

    acc_d    = acc_q;
    c_d      = c_q;
    state_d  = state_q;
    regs_d   = regs_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    pp_d     = pp_q;

    if (ena && busy) begin
      pp_d = pp_next;
      if (state_q == S_MUL4) begin
        acc_d   = pp_next[DATA_W-1:0];
        c_d     = |pp_next[2*DATA_W-1:DATA_W];
        state_d = S_IDLE;
      end else begin
        state_d = state_q + 3'd1;
      end
    end else if (accept) begin
      case (opcode)
        4'h1: acc_d = imm_ext;
        4'h2: begin
          sum_w = {1'b0, acc_q} + {1'b0, imm_ext};
          {c_d, acc_d} = sum_w;
        end
        4'h3: begin
          acc_d = acc_q - imm_ext;
          c_d   = (acc_q < imm_ext);
        end
        4'h4: acc_d = acc_q & imm_ext;
        4'h5: acc_d = acc_q | imm_ext;
        4'h6: acc_d = acc_q ^ imm_ext;
        4'h7: begin
          sum_w = {1'b0, acc_q} + {1'b0, imm_ext} + (DATA_W+1)'(c_q);
          {c_d, acc_d} = sum_w;
        end
        4'h8: regs_d[idx] = acc_q;
        4'h9: acc_d = reg_rd;
        4'hA: begin
          sum_w = {1'b0, acc_q} + {1'b0, reg_rd};
          {c_d, acc_d} = sum_w;
        end
        4'hB: begin
          c_d   = acc_q[DATA_W-1];
          acc_d = {acc_q[DATA_W-2:0], 1'b0};
        end
        4'hC: begin
          c_d   = acc_q[0];
          acc_d = {1'b0, acc_q[DATA_W-1:1]};
        end
        // high nibble lands at bits 7:4; at DATA_W=4 the slice returns acc unchanged
        4'hD: acc_d = ldh_w[DATA_W-1:0];
        4'hE: begin
          mcand_d  = acc_q;
          mplier_d = imm;
          pp_d     = '0;
          state_d  = S_MUL1;
        end
        4'hF: begin
          acc_d = '0;
          c_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      c_q      <= 1'b0;
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      pp_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      pp_q     <= pp_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rb_idx  = uio_in[2 +: IDX_W];
    uo_out  = uio_in[1] ? 8'(regs_q[rb_idx]) : 8'(acc_q);
    uio_out = {busy, c_q, (acc_q == '0), 5'b0};
    uio_oe  = 8'hE0;
  end

endmodule
